// File: rtl/half_pkg.sv
// Shared fp16 types and ordering helpers.
// Used by the argmax stage and later reduction stages.
package half_pkg;

  localparam int         HALF_W       = 16;
  localparam logic [4:0] HALF_EXP_MAX = 5'h1F;

  typedef logic [HALF_W-1:0] half_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } argmax_state_t;

  function automatic logic half_is_nan(half_t h);
    return (h[14:10] == HALF_EXP_MAX) && (h[9:0] != 10'd0);
  endfunction

  // Strict a > b; NaN never wins and loses to any non-NaN.
  function automatic logic half_gt(half_t a, half_t b);
    logic r;
    r = 1'b0;
    if (half_is_nan(a)) begin
      r = 1'b0;
    end else if (half_is_nan(b)) begin
      r = 1'b1;
    end else if (a[14:0] == 15'd0 && b[14:0] == 15'd0) begin
      r = 1'b0;
    end else begin
      unique case ({a[15], b[15]})
        2'b00:   r = a[14:0] > b[14:0];
        2'b11:   r = a[14:0] < b[14:0];
        2'b01:   r = 1'b1;
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/half_compare_gt.sv
// Combinational fp16 strict greater-than.
// Shared by argmax and max-pool reductions.
module half_compare_gt
  import half_pkg::*;
(
  input  half_t a,
  input  half_t b,
  output logic  gt
);

  assign gt = half_gt(a, b);

endmodule

// File: rtl/half_argmax_classifier.sv
// Sequential fp16 argmax: one element per clock.
// Emits class index and value as a one-cycle pulse.
module half_argmax_classifier
  import half_pkg::*;
#(
  parameter int LENGTH = 10,
  parameter int IDX_W  = $clog2(LENGTH) + ((LENGTH == 1) ? 1 : 0)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  half_t            x [LENGTH],
  output logic             out_valid,
  output logic [IDX_W-1:0] class_idx,
  output half_t            max_val,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LENGTH - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  argmax_state_t    state;
  argmax_state_t    state_n;
  half_t            vec [LENGTH];
  half_t            best;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] idx;
  logic             gt;
  logic             accept;
  logic             last;

  assign accept = in_valid & in_ready;
  assign last   = (idx == LAST);

  half_compare_gt u_cmp (
    .a  (vec[idx]),
    .b  (best),
    .gt (gt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rstn) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_valid)
          state_n = (LENGTH > 1) ? ST_SCAN : ST_DONE;
      end
      ST_SCAN: begin
        in_ready = 1'b0;
        if (last) state_n = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (in_valid)
          state_n = (LENGTH > 1) ? ST_SCAN : ST_DONE;
        else
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Vector capture, running best and result registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int k = 0; k < LENGTH; k++) vec[k] <= '0;
      best      <= '0;
      best_idx  <= '0;
      idx       <= '0;
      class_idx <= '0;
      max_val   <= '0;
    end else if (accept) begin
      vec      <= x;
      best     <= x[0];
      best_idx <= '0;
      idx      <= ONE;
      if (LENGTH == 1) begin
        class_idx <= '0;
        max_val   <= x[0];
      end
    end else if (state == ST_SCAN) begin
      idx <= idx + ONE;
      if (gt) begin
        best     <= vec[idx];
        best_idx <= idx;
      end
      if (last) begin
        class_idx <= gt ? idx : best_idx;
        max_val   <= gt ? vec[idx] : best;
      end
    end
  end

  // Sticky flag for pulses dropped during a scan.
  always_ff @(posedge clk) begin
    if (rstn)                      overrun <= 1'b0;
    else if (in_valid && !in_ready) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_half_argmax_classifier.sv
// Randomized and directed bench for half_argmax_classifier.
// Reference: fp16 decoded to real, NaN handled explicitly.
module tb_half_argmax_classifier;

  logic        clk = 1'b0;
  logic        rstn;
  logic        iv10, iv1;
  logic        ir10, ir1;
  logic        ov10, ov1;
  logic [3:0]  ci10;
  logic [0:0]  ci1;
  logic [15:0] mv10, mv1;
  logic        or10, or1;
  logic [15:0] x10 [10];
  logic [15:0] x1  [1];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  half_argmax_classifier #(.LENGTH(10)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (iv10),
    .in_ready  (ir10),
    .x         (x10),
    .out_valid (ov10),
    .class_idx (ci10),
    .max_val   (mv10),
    .overrun   (or10)
  );

  half_argmax_classifier #(.LENGTH(1)) u_one (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .x         (x1),
    .out_valid (ov1),
    .class_idx (ci1),
    .max_val   (mv1),
    .overrun   (or1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_nan(logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 0);
  endfunction

  function automatic real h2r(logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 31) begin
      v = 1.0e9;
    end else if (e == 0) begin
      v = real'(int'(h[9:0])) / 16777216.0;
    end else begin
      v = real'(1024 + int'(h[9:0]));
      for (int k = 0; k < e; k++) v = v * 2.0;
      v = v / 33554432.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic int ref_idx10();
    int b;
    b = 0;
    for (int i = 1; i < 10; i++) begin
      if (!is_nan(x10[i]) &&
          (is_nan(x10[b]) || h2r(x10[i]) > h2r(x10[b])))
        b = i;
    end
    return b;
  endfunction

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 10; i++) x10[i] = v;
  endtask

  task automatic pulse10();
    @(negedge clk);
    iv10 = 1'b1;
    @(negedge clk);
    iv10 = 1'b0;
  endtask

  task automatic run10(input string tag);
    int          ei, lat, lowc;
    logic [15:0] ev;
    ei   = ref_idx10();
    ev   = x10[ei];
    lat  = 0;
    lowc = 0;
    pulse10();
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      if (ov10) begin
        lat = k;
        break;
      end
      if (!ir10) lowc++;
    end
    chk({tag, "_lat"},  32'(lat), 32'd10);
    chk({tag, "_busy"}, 32'(lowc), 32'd9);
    chk({tag, "_idx"},  32'(ci10), 32'(ei));
    chk({tag, "_val"},  32'(mv10), 32'(ev));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(ov10), 32'd0);
    chk({tag, "_hold"},  32'(ci10), 32'(ei));
  endtask

  task automatic run1(input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      if (ov1) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_idx"}, 32'(ci1), 32'd0);
    chk({tag, "_val"}, 32'(mv1), 32'(x1[0]));
  endtask

  function automatic logic [15:0] rnd_half();
    logic [15:0] sp [8];
    sp[0] = 16'h0000; sp[1] = 16'h8000;
    sp[2] = 16'h7C00; sp[3] = 16'hFC00;
    sp[4] = 16'h7E00; sp[5] = 16'h7C01;
    sp[6] = 16'h0001; sp[7] = 16'h8001;
    if ($urandom_range(0, 3) == 0)
      return sp[$urandom_range(0, 7)];
    return 16'($urandom);
  endfunction

  initial begin
    int cnt;
    rstn = 1'b1;
    iv10 = 1'b0;
    iv1  = 1'b0;
    fill(16'h0000);
    x1[0] = 16'h0000;

    repeat (3) @(negedge clk);
    rstn = 1'b0;
    chk("rst_ready", 32'(ir10), 32'd1);
    chk("rst_ov",    32'(ov10), 32'd0);
    chk("rst_idx",   32'(ci10), 32'd0);
    chk("rst_val",   32'(mv10), 32'h0);
    chk("rst_orun",  32'(or10), 32'd0);

    fill(16'h0000);
    x10[1] = 16'h3800; x10[2] = 16'h3C00; x10[3] = 16'h3400;
    run10("basic");

    fill(16'hBC00);
    x10[1] = 16'h3C00; x10[2] = 16'h3C00; x10[3] = 16'h8000;
    run10("tie");
    fill(16'hBC00);
    x10[7] = 16'hB800;
    run10("neg");
    fill(16'h8000);
    x10[1] = 16'h0000;
    run10("zero");
    chk("zero_exp", 32'(ci10), 32'd0);

    fill(16'h3C00);
    x10[0] = 16'h7E00; x10[4] = 16'h7C00;
    run10("inf");
    fill(16'h7E00);
    run10("allnan");

    fill(16'h0000);
    x10[1] = 16'h3800; x10[2] = 16'h3C00; x10[3] = 16'h3400;
    pulse10();
    cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5) begin
        fill(16'h7BFF);
        iv10 = 1'b1;
      end
      if (k == 6) iv10 = 1'b0;
      if (k != 10 && k != 20 && ov10) cnt++;
      if (k == 10) begin
        chk("hs_ov1",   32'(ov10), 32'd1);
        chk("hs_idx1",  32'(ci10), 32'd2);
        chk("hs_val1",  32'(mv10), 32'h3C00);
        chk("hs_orun",  32'(or10), 32'd1);
        fill(16'hC000);
        x10[8] = 16'h4000;
        iv10 = 1'b1;
      end
      if (k == 11) iv10 = 1'b0;
      if (k == 20) begin
        chk("hs_ov2",  32'(ov10), 32'd1);
        chk("hs_idx2", 32'(ci10), 32'd8);
        chk("hs_val2", 32'(mv10), 32'h4000);
      end
    end
    chk("hs_stray", 32'(cnt), 32'd0);
    chk("hs_sticky", 32'(or10), 32'd1);

    fill(16'h3C00);
    x10[6] = 16'h4200;
    pulse10();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    chk("mid_ready", 32'(ir10), 32'd1);
    chk("mid_idx",   32'(ci10), 32'd0);
    chk("mid_val",   32'(mv10), 32'h0);
    chk("mid_orun",  32'(or10), 32'd0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ov10) cnt++;
    end
    chk("mid_noout", 32'(cnt), 32'd0);
    run10("post");

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 10; i++) begin
        x10[i] = rnd_half();
        if (i > 0 && $urandom_range(0, 5) == 0)
          x10[i] = x10[$urandom_range(0, i - 1)];
      end
      run10($sformatf("rnd%0d", t));
    end

    x1[0] = 16'h3C00;
    run1("one_a");
    x1[0] = 16'h7E00;
    run1("one_b");
    chk("one_orun", 32'(or1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
